// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC decimator family.
package adc_pkg;
  localparam int ADC_DATA_W = 16;
  localparam int ADC_CNT_W  = 4;

  localparam logic [ADC_CNT_W-1:0] ADC_LEGACY_RATIO = 4'd10;

  typedef logic [ADC_DATA_W-1:0] adc_sample_t;
endpackage

// File: rtl/adc_dec_counter.sv
// Phase counter with a shadowed period register; emits a wrap strobe on the
// last enabled cycle of each period.
module adc_dec_counter
  import adc_pkg::*;
#(
  parameter int CNT_W = ADC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [CNT_W-1:0] ratio_i,
  output logic [CNT_W-1:0] phase_o,
  output logic             wrap_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             loaded_q, loaded_d;
  logic [CNT_W-1:0] limit;

  // Until the first enabled cycle the shadow is stale, so the live ratio rules.
  assign limit   = loaded_q ? shadow_q : ratio_i;
  assign wrap_o  = en_i && (cnt_q == limit);
  assign phase_o = cnt_q;

  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    loaded_d = loaded_q;
    if (en_i) begin
      loaded_d = 1'b1;
      if (cnt_q == limit) begin
        cnt_d    = '0;
        shadow_d = ratio_i;
      end else begin
        cnt_d    = cnt_q + 1'b1;
        shadow_d = limit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      loaded_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      loaded_q <= loaded_d;
    end
  end
endmodule

// File: rtl/adc_decimator.sv
// Programmable-ratio ADC decimator. Define ADC_DEC_AVG_EN to publish the
// saturated, shifted period sum instead of the last sample of each period.
module adc_decimator
  import adc_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int CNT_W  = ADC_CNT_W
`ifdef ADC_DEC_AVG_EN
  ,
  parameter int AVG_SHIFT = 0
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  ratio,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic [CNT_W-1:0]  phase
);
  logic [DATA_W-1:0] in_q, in_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] sample_d;
  logic              wrap;

  adc_dec_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .ratio_i(ratio),
    .phase_o(phase),
    .wrap_o (wrap)
  );

`ifdef ADC_DEC_AVG_EN
  localparam int ACC_W = DATA_W + CNT_W;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   sum_sh;

  // A period holds at most 2^CNT_W samples, so ACC_W bits never overflow.
  assign sum      = {1'b0, acc_q} + (ACC_W + 1)'(in_q);
  assign sum_sh   = sum >> AVG_SHIFT;
  assign sample_d = (|sum_sh[ACC_W:DATA_W]) ? {DATA_W{1'b1}} : sum_sh[DATA_W-1:0];

  always_comb begin
    acc_d = acc_q;
    if (en) begin
      acc_d = wrap ? '0 : sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  assign sample_d = in_q;
`endif

  always_comb begin
    in_d        = in;
    out_valid_d = wrap;
    out_d       = wrap ? sample_d : out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      in_q        <= in_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
endmodule
